rr_arbiter8: RTL and testbench
==============================

RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
- REQ-001: Parameter TIMEOUT, default 16, max cycles a grant is held without gnt_ack; 0 disables the timeout.
- REQ-002: Parameter CNT_W, default 5, width of the hold counter; TIMEOUT SHALL be at most 2**CNT_W-1.
- REQ-003: clk  input  1  single clock; all state changes on rising edge.
- REQ-004: rst_n  input  1  reset, asynchronous assert, active-low.
- REQ-005: req  input  8  request vector, bit i = requester i, level-sensitive.
- REQ-006: gnt_ack  input  1  downstream consumer finished with the current grant.
- REQ-007: gnt  output  8  registered grant, always all-zero or exactly one-hot; feeds the 8-to-3 encoder stage directly.
- REQ-008: gnt_valid  output  1  registered; high exactly when gnt is non-zero.
- REQ-009: timeout_err  output  1  registered one-cycle pulse on forced grant release.

Function
- REQ-010: The FSM SHALL have two states, IDLE and GRANT.
- REQ-011: IDLE with req==0 SHALL stay in IDLE with gnt=0 and gnt_valid=0.
- REQ-012: IDLE with req!=0 SHALL pick the winner as the first set req bit scanning upward from (ptr+1) mod 8 with wrap-around, then move to GRANT.
- REQ-013: Grant latency SHALL be 1 cycle: req sampled on edge N, gnt and gnt_valid asserted after edge N.
- REQ-014: In GRANT, gnt SHALL hold stable regardless of req changes, including withdrawal of the granted bit.
- REQ-015: In GRANT, gnt_ack=1 SHALL cause ptr<=winner index, gnt<=0, gnt_valid<=0 and a return to IDLE on that edge.
- REQ-016: Between consecutive grants there SHALL be at least one IDLE cycle with gnt=0.
- REQ-017: gnt_ack SHALL be ignored in IDLE.
- REQ-018: The hold counter SHALL clear on entry to GRANT and increment each cycle in GRANT.
- REQ-019: When TIMEOUT!=0 and the counter reaches TIMEOUT-1 without ack, the block SHALL release exactly as for ack (ptr advances) and pulse timeout_err for one cycle.
- REQ-020: If gnt_ack and the timeout occur in the same cycle, ack SHALL win and timeout_err SHALL stay 0.
- REQ-021: With all eight bits requesting continuously, grants SHALL rotate 0,1,...,7,0; no requester waits more than 7 grants.
- REQ-022: ptr SHALL be 3 bits and SHALL wrap from 7 to 0 naturally.

Reset
- REQ-023: rst_n low SHALL immediately force state=IDLE, gnt=0, gnt_valid=0, timeout_err=0, counter=0, ptr=7, so requester 0 has top priority first.
- REQ-024: Reset asserted during GRANT SHALL drop the grant asynchronously without any timeout_err pulse.
- REQ-025: After rst_n deasserts, the first arbitration SHALL occur on the first rising edge with rst_n high.

Structure
- REQ-026: Package arb_pkg SHALL hold NUM_REQ=8, the IDX_W=3 constant, and the FSM state enum typedef.
- REQ-027: Rotating-priority selection SHALL live in one combinational sub-module rr_pick (inputs req and ptr; outputs one-hot winner and its index).
- REQ-028: All outputs SHALL be registered; no combinational path from req or gnt_ack to any output.

Verification
- REQ-029: Reset, then req=8'b0000_0101 with immediate ack -> gnt=8'h01, then 8'h04, then 8'h01.
- REQ-030: req=8'hFF held, ack one cycle after each grant -> gnt sequence 01,02,04,...,80,01 with a gnt=0 cycle between each grant.
- REQ-031: req=8'h10 then withdrawn after grant, no ack, TIMEOUT=16 -> gnt=8'h10 held 16 cycles, then released with a single timeout_err pulse.
- REQ-032: gnt_ack asserted on the exact timeout cycle -> release with timeout_err=0.
- REQ-033: rst_n pulled low mid-GRANT with gnt=8'h08 -> gnt=0 immediately; after release, req=8'h09 -> gnt=8'h01 (ptr back at 7).
- REQ-034: Every cycle, assert gnt is zero or one-hot and gnt_valid equals |gnt.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared constants and FSM state type for the 8-way round-robin arbiter.
package arb_pkg;
  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;
endpackage

// File: rtl/rr_pick.sv
// Rotating-priority winner selection: first set req bit scanning upward
// from ptr+1 with wrap-around. Purely combinational.
module rr_pick
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   winner_idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    winner     = '0;
    winner_idx = '0;
    found      = 1'b0;
    cand       = '0;
    // Offset NUM_REQ truncates to zero, so ptr itself is scanned last.
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ptr + IDX_W'(k);
      if (!found && req[cand]) begin
        found      = 1'b1;
        winner_idx = cand;
      end
    end
    if (found) begin
      winner = NUM_REQ'(1) << winner_idx;
    end
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter with held grants, ack release and
// an optional hold timeout that forces release and flags timeout_err.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               gnt_ack,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic               timeout_err
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  state_t             state;
  logic [CNT_W-1:0]   hold_cnt;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   cur_idx;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               timeout_hit;

  rr_pick u_pick (
    .req        (req),
    .ptr        (ptr),
    .winner     (pick_gnt),
    .winner_idx (pick_idx)
  );

  assign timeout_hit = (TIMEOUT != 0) && (hold_cnt == HOLD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      gnt         <= '0;
      gnt_valid   <= 1'b0;
      timeout_err <= 1'b0;
      hold_cnt    <= '0;
      ptr         <= IDX_W'(NUM_REQ - 1);
      cur_idx     <= '0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            gnt       <= pick_gnt;
            gnt_valid <= 1'b1;
            cur_idx   <= pick_idx;
            hold_cnt  <= '0;
            state     <= GRANT;
          end
        end
        GRANT: begin
          // Ack takes priority over a timeout landing on the same edge.
          if (gnt_ack || timeout_hit) begin
            ptr         <= cur_idx;
            gnt         <= '0;
            gnt_valid   <= 1'b0;
            timeout_err <= !gnt_ack;
            state       <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          gnt       <= '0;
          gnt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed scenarios plus randomized
// traffic compared against a behavioural round-robin model.
module tb_rr_arbiter8;

  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = '0;
  logic       gnt_ack = 1'b0;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic       timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  // Model: who holds the grant (-1 = nobody), how many cycles it has been
  // visible, last winner, and whether a forced release just happened.
  int m_idx  = -1;
  int m_held = 0;
  int m_last = 7;
  bit m_terr = 1'b0;

  always #5 clk = ~clk;

  rr_arbiter8 #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .gnt_ack     (gnt_ack),
    .gnt         (gnt),
    .gnt_valid   (gnt_valid),
    .timeout_err (timeout_err)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int next_winner(input logic [7:0] r, input int last);
    for (int k = 1; k <= 8; k++) begin
      int c;
      c = (last + k) % 8;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [7:0] model_gnt();
    logic [7:0] g;
    g = '0;
    if (m_idx >= 0) g[m_idx] = 1'b1;
    return g;
  endfunction

  task automatic model_reset();
    m_idx  = -1;
    m_held = 0;
    m_last = 7;
    m_terr = 1'b0;
  endtask

  // Predict the state after the next rising edge from the current inputs.
  task automatic model_edge();
    m_terr = 1'b0;
    if (m_idx < 0) begin
      m_idx  = next_winner(req, m_last);
      m_held = (m_idx >= 0) ? 1 : 0;
    end else if (gnt_ack) begin
      m_last = m_idx;
      m_idx  = -1;
    end else if (TIMEOUT != 0 && m_held == TIMEOUT) begin
      m_last = m_idx;
      m_idx  = -1;
      m_terr = 1'b1;
    end else begin
      m_held++;
    end
  endtask

  task automatic compare_all();
    check_value("gnt", gnt, model_gnt());
    check_value("gnt_valid", gnt_valid, (m_idx >= 0));
    check_value("timeout_err", timeout_err, m_terr);
    check_value("onehot0", $onehot0(gnt), 1);
    check_value("valid_vs_gnt", gnt_valid, |gnt);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
    $display("cyc req=%02h ack=%0b -> gnt=%02h v=%0b terr=%0b", req, gnt_ack, gnt, gnt_valid, timeout_err);
  endtask

  // Assert reset mid-cycle, check the asynchronous clear, release on a negedge.
  task automatic apply_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_value("rst_gnt", gnt, 8'h00);
    check_value("rst_valid", gnt_valid, 1'b0);
    check_value("rst_terr", timeout_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset applied at %0t", $time);
  endtask

  initial begin
    int held;
    int pulses;
    int ack_pct;

    #23;
    check_value("init_gnt", gnt, 8'h00);
    check_value("init_valid", gnt_valid, 1'b0);
    check_value("init_terr", timeout_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Two requesters, immediate ack: 01, idle, 04, idle, 01.
    req = 8'h05; gnt_ack = 1'b1;
    step(); check_value("seq05_a", gnt, 8'h01);
    step(); check_value("seq05_gap", gnt, 8'h00);
    step(); check_value("seq05_b", gnt, 8'h04);
    step();
    step(); check_value("seq05_c", gnt, 8'h01);

    apply_reset();

    // All requesting, ack one cycle after each grant: strict rotation.
    req = 8'hFF; gnt_ack = 1'b0;
    for (int k = 0; k < 9; k++) begin
      logic [7:0] exp_g;
      exp_g = 8'h01 << (k % 8);
      gnt_ack = 1'b0;
      step(); check_value("rot_gnt", gnt, exp_g);
      gnt_ack = 1'b1;
      step(); check_value("rot_gap", gnt, 8'h00);
    end

    // Single request withdrawn after grant, no ack: held TIMEOUT cycles.
    req = 8'h00; gnt_ack = 1'b0;
    step();
    req = 8'h10;
    step(); check_value("to_grant", gnt, 8'h10);
    req = 8'h00;
    held = 1; pulses = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (gnt == 8'h10) held++;
      if (timeout_err) pulses++;
    end
    check_value("to_held", held, TIMEOUT);
    check_value("to_pulses", pulses, 1);

    // Ack on the exact timeout cycle: release without timeout_err.
    req = 8'h10;
    step(); check_value("ackto_grant", gnt, 8'h10);
    req = 8'h00;
    for (int k = 0; k < TIMEOUT - 1; k++) step();
    gnt_ack = 1'b1;
    step();
    check_value("ackto_gnt", gnt, 8'h00);
    check_value("ackto_terr", timeout_err, 1'b0);
    gnt_ack = 1'b0;
    step();

    // Reset mid-grant, then priority restarts at requester 0.
    apply_reset();
    req = 8'h08;
    step(); check_value("mid_grant", gnt, 8'h08);
    step();
    apply_reset();
    req = 8'h09;
    step(); check_value("post_rst", gnt, 8'h01);
    gnt_ack = 1'b1;
    step();

    // Randomized traffic with varying ack pressure and rare resets.
    for (int blk = 0; blk < 8; blk++) begin
      ack_pct = (blk % 3 == 0) ? 0 : ((blk % 3 == 1) ? 15 : 60);
      for (int k = 0; k < 60; k++) begin
        req     = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom & $urandom);
        gnt_ack = ($urandom_range(0, 99) < ack_pct);
        if ($urandom_range(0, 199) == 0) apply_reset();
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
    $fatal(1);
  end

endmodule
